keccak_absorb_packer: RTL

- Streaming front end for the Keccak permutation core.
- Accepts message bytes in IN_WIDTH-bit beats and packs them into rate-sized blocks for the selected keccak_mode (SHA3_256, SHA3_512, SHAKE128, SHAKE256).
- Applies pad10*1 with the mode's domain-separation suffix and hands each complete block to the permutation/absorb stage over a valid/ready handshake.
- Adds runtime mode selection, variable rate, padding generation and back-pressure buffering.

---
 rtl/keccak_absorb_packer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/keccak_absorb_packer.sv
// Purpose: packs message beats into rate-sized Keccak blocks and applies pad10*1 with the mode's domain suffix.
// Latency: a block-completing beat gives blk_valid_o the next cycle; a last beat gives it two cycles later via PAD.
// Backpressure: single block buffer; in_ready_o stays low while a block waits on blk_ready_i, and the block is held stable.
module keccak_absorb_packer #(
  parameter int IN_WIDTH      = 64,
  parameter int MAX_RATE_BITS = 1344
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [2:0]                        mode_i,
  input  logic                              start_i,
  input  logic [IN_WIDTH-1:0]               in_data_i,
  input  logic [$clog2(IN_WIDTH/8+1)-1:0]   in_bytes_i,
  input  logic                              in_last_i,
  input  logic                              in_valid_i,
  output logic                              in_ready_o,
  output logic [MAX_RATE_BITS-1:0]          blk_data_o,
  output logic [7:0]                        blk_rate_o,
  output logic                              blk_last_o,
  output logic                              blk_valid_o,
  input  logic                              blk_ready_i,
  output logic                              err_o
);

  localparam int IN_BYTES  = IN_WIDTH / 8;
  localparam int MAX_BYTES = MAX_RATE_BITS / 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_PAD,
    S_EMIT
  } state_t;

  state_t                     state_q, state_d;
  logic [MAX_RATE_BITS-1:0]   blk_q;
  logic [MAX_RATE_BITS-1:0]   fill_buf;
  logic [MAX_RATE_BITS-1:0]   pad_buf;
  logic [7:0]                 ptr_q;
  logic [7:0]                 ptr_sum;
  logic [1:0]                 mode_q;
  logic                       last_q;
  logic                       extra_q;
  logic                       err_q;
  logic [7:0]                 rate_w;
  logic [7:0]                 suffix_w;
  logic                       beat_fire;
  logic                       start_ok;
  int                         widx;
  int                         pidx;
  int                         ridx;

  assign beat_fire = (state_q == S_FILL) && in_valid_i;
  assign start_ok  = start_i && !mode_i[2];
  assign ptr_sum   = ptr_q + 8'(in_bytes_i);

  // Rate and domain-separation suffix of the latched mode
  always_comb begin
    rate_w   = 8'd136;
    suffix_w = mode_q[1] ? 8'h1F : 8'h06;
    case (mode_q)
      2'd0:    rate_w = 8'd136;
      2'd1:    rate_w = 8'd72;
      2'd2:    rate_w = 8'd168;
      default: rate_w = 8'd136;
    endcase
  end

  // Buffer image after writing the valid bytes of the current beat at the pointer
  always_comb begin
    fill_buf = blk_q;
    widx     = 0;
    for (int j = 0; j < IN_BYTES; j++) begin
      if (j < int'(in_bytes_i)) begin
        widx = int'(ptr_q) + j;
        if (widx < MAX_BYTES) fill_buf[8*widx +: 8] = in_data_i[8*j +: 8];
      end
    end
  end

  // Buffer image after pad10*1; both XORs may hit the same byte when ptr = rate-1
  always_comb begin
    pad_buf = blk_q;
    pidx    = int'(ptr_q);
    ridx    = int'(rate_w) - 1;
    if (pidx < MAX_BYTES) pad_buf[8*pidx +: 8] = pad_buf[8*pidx +: 8] ^ suffix_w;
    if (ridx >= 0 && ridx < MAX_BYTES) pad_buf[8*ridx +: 8] = pad_buf[8*ridx +: 8] ^ 8'h80;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_ok) state_d = S_FILL;
      S_FILL: begin
        if (beat_fire) begin
          if (ptr_sum >= rate_w) state_d = S_EMIT;
          else if (in_last_i)    state_d = S_PAD;
        end
      end
      S_PAD:  state_d = S_EMIT;
      S_EMIT: begin
        if (blk_ready_i) begin
          if (last_q)       state_d = S_IDLE;
          else if (extra_q) state_d = S_PAD;
          else              state_d = S_FILL;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Block buffer, pointer, latched mode and block flags
  always_ff @(posedge clk) begin
    if (rst) begin
      blk_q   <= '0;
      ptr_q   <= '0;
      mode_q  <= 2'd0;
      last_q  <= 1'b0;
      extra_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= (state_q == S_IDLE) && start_i && mode_i[2];
      case (state_q)
        S_IDLE: begin
          if (start_ok) begin
            mode_q  <= mode_i[1:0];
            blk_q   <= '0;
            ptr_q   <= '0;
            last_q  <= 1'b0;
            extra_q <= 1'b0;
          end
        end
        S_FILL: begin
          if (beat_fire) begin
            blk_q   <= fill_buf;
            ptr_q   <= ptr_sum;
            last_q  <= 1'b0;
            // A last beat that exactly fills the block leaves a padding-only block to follow
            extra_q <= in_last_i && (ptr_sum >= rate_w);
          end
        end
        S_PAD: begin
          blk_q   <= pad_buf;
          last_q  <= 1'b1;
          extra_q <= 1'b0;
        end
        S_EMIT: begin
          if (blk_ready_i && !last_q) begin
            blk_q <= '0;
            ptr_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready_o  = (state_q == S_FILL);
  assign blk_valid_o = (state_q == S_EMIT);
  assign blk_last_o  = (state_q == S_EMIT) && last_q;
  assign blk_rate_o  = (state_q == S_EMIT) ? rate_w : 8'd0;
  assign blk_data_o  = blk_q;
  assign err_o       = err_q;

endmodule
